// File: rtl/out_port_arb.sv
// out_port_arb: round-robin arbiter that hands ownership of one shared output
// port to a single input channel for the duration of a packet. It grants with
// registered resp/nresp pulses, forwards the owner's words with one cycle of
// latency, and aborts a packet whose owner stays silent for too long.
module out_port_arb #(
  parameter int unsigned PORTNUM = 16,
  parameter int unsigned DWIDTH  = 32,
  parameter logic [7:0]  TIMEOUT = 8'd255
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [PORTNUM-1:0]         i_req,
  output logic [PORTNUM-1:0]         o_resp,
  output logic [PORTNUM-1:0]         o_nresp,
  input  logic [PORTNUM*DWIDTH-1:0]  i_data,
  input  logic [PORTNUM-1:0]         i_data_vld,
  input  logic [PORTNUM-1:0]         i_eop,
  output logic [DWIDTH-1:0]          o_wr_data,
  output logic                       o_wr_vld,
  output logic                       o_wr_eop,
  output logic [$clog2(PORTNUM)-1:0] o_grant_id,
  output logic                       o_ready,
  output logic                       o_abort
);

  localparam int unsigned IW = $clog2(PORTNUM);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] XFER = 1'b1;

  logic [0:0]         state;
  logic [IW-1:0]      rr_ptr;
  logic [7:0]         idle_cnt;

  logic [IW-1:0]      winner;
  logic [IW-1:0]      idx;
  logic               found;
  logic               any_req;
  logic [PORTNUM-1:0] win_mask;

  logic [DWIDTH-1:0]  words [PORTNUM];
  logic [DWIDTH-1:0]  own_data;
  logic               own_vld;
  logic               own_eop;
  logic               timed_out;

  assign any_req   = |i_req;
  assign win_mask  = PORTNUM'(1) << winner;
  assign o_ready   = (state == IDLE);

  // Round-robin search: first requesting channel at or above rr_ptr, wrapping.
  always_comb begin
    winner = rr_ptr;
    idx    = rr_ptr;
    found  = 1'b0;
    for (int unsigned i = 0; i < PORTNUM; i++) begin
      idx = rr_ptr + IW'(i);
      if (!found && i_req[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

  // Unflatten the channel data bus and select the current owner's lane.
  always_comb begin
    for (int unsigned k = 0; k < PORTNUM; k++) begin
      words[k] = i_data[k*DWIDTH +: DWIDTH];
    end
    own_data = words[o_grant_id];
    own_vld  = i_data_vld[o_grant_id];
    own_eop  = i_eop[o_grant_id];
  end

  // The idle counter is compared before incrementing, so the abort fires on
  // the (TIMEOUT+1)th consecutive silent cycle of the owner; o_abort and the
  // return to IDLE become visible in the same cycle.
  assign timed_out = (state == XFER) && !own_vld && (idle_cnt == TIMEOUT);

  // Ownership control: state, round-robin pointer, grant id, idle timer, abort.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state      <= IDLE;
      rr_ptr     <= '0;
      o_grant_id <= '0;
      idle_cnt   <= '0;
      o_abort    <= 1'b0;
    end else begin
      o_abort <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            state      <= XFER;
            o_grant_id <= winner;
            rr_ptr     <= winner + IW'(1);
            idle_cnt   <= '0;
          end
        end
        XFER: begin
          if (own_vld) begin
            idle_cnt <= '0;
            if (own_eop) begin
              state <= IDLE;
            end
          end else if (timed_out) begin
            o_abort  <= 1'b1;
            idle_cnt <= '0;
            state    <= IDLE;
          end else begin
            idle_cnt <= idle_cnt + 8'd1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Request handshake: grant the winner in IDLE, reject everything else.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_resp  <= '0;
      o_nresp <= '0;
    end else begin
      o_resp  <= '0;
      o_nresp <= '0;
      if (state == IDLE) begin
        if (any_req) begin
          o_resp  <= win_mask;
          o_nresp <= i_req & ~win_mask;
        end
      end else begin
        o_nresp <= i_req;
      end
    end
  end

  // Datapath: register the owner's word; data is forced to zero when not valid.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      o_wr_data <= '0;
      o_wr_vld  <= 1'b0;
      o_wr_eop  <= 1'b0;
    end else begin
      o_wr_data <= '0;
      o_wr_vld  <= 1'b0;
      o_wr_eop  <= 1'b0;
      if (state == XFER && own_vld) begin
        o_wr_data <= own_data;
        o_wr_vld  <= 1'b1;
        o_wr_eop  <= own_eop;
      end
    end
  end

endmodule

// File: tb/tb_out_port_arb.sv
// tb_out_port_arb: scoreboard bench for out_port_arb. The driver applies
// stimulus, advances a packet-level reference model and queues the expected
// responses; a single monitor process pops and compares them mid-cycle.
module tb_out_port_arb;

  localparam int N  = 16;
  localparam int DW = 32;
  localparam int TO = 255;

  logic              clk;
  logic              rst_n;
  logic [N-1:0]      req;
  logic [N-1:0]      resp;
  logic [N-1:0]      nresp;
  logic [N*DW-1:0]   data;
  logic [N-1:0]      vld;
  logic [N-1:0]      eop;
  logic [DW-1:0]     wr_data;
  logic              wr_vld;
  logic              wr_eop;
  logic [3:0]        grant_id;
  logic              ready;
  logic              abort;

  out_port_arb #(
    .PORTNUM (N),
    .DWIDTH  (DW),
    .TIMEOUT (8'd255)
  ) dut (
    .i_clk      (clk),
    .i_rst_n    (rst_n),
    .i_req      (req),
    .o_resp     (resp),
    .o_nresp    (nresp),
    .i_data     (data),
    .i_data_vld (vld),
    .i_eop      (eop),
    .o_wr_data  (wr_data),
    .o_wr_vld   (wr_vld),
    .o_wr_eop   (wr_eop),
    .o_grant_id (grant_id),
    .o_ready    (ready),
    .o_abort    (abort)
  );

  typedef struct { int t; logic [N-1:0] resp; logic [N-1:0] nresp; } hs_t;
  typedef struct { int t; logic [DW-1:0] data; logic eop; } wr_t;
  typedef struct { int t; logic ready; int gid; } st_t;

  hs_t hs_q[$];
  wr_t wr_q[$];
  int  ab_q[$];
  st_t st_q[$];

  int  cyc = 0;
  int  checks = 0;
  int  errors = 0;
  logic rst_probe = 1'b0;
  logic done = 1'b0;

  // Reference model state: is the port owned, by whom, where the search starts.
  bit  m_busy;
  int  m_owner;
  int  m_ptr;
  int  m_idle;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int pick(input logic [N-1:0] r, input int p);
    for (int k = 0; k < N; k++) begin
      if (r[(p + k) % N]) return (p + k) % N;
    end
    return 0;
  endfunction

  // Model of one clock edge with the inputs currently applied.
  task automatic model_edge();
    int t;
    int w;
    logic [N-1:0] m;
    t = cyc + 1;
    if (!m_busy) begin
      if (req != '0) begin
        w = pick(req, m_ptr);
        m = '0;
        m[w] = 1'b1;
        hs_q.push_back('{t, m, req & ~m});
        m_busy  = 1'b1;
        m_owner = w;
        m_ptr   = (w + 1) % N;
        m_idle  = 0;
      end
    end else begin
      if (req != '0) hs_q.push_back('{t, '0, req});
      if (vld[m_owner]) begin
        wr_q.push_back('{t, data[m_owner*DW +: DW], eop[m_owner]});
        m_idle = 0;
        if (eop[m_owner]) m_busy = 1'b0;
      end else if (m_idle == TO) begin
        ab_q.push_back(t);
        m_busy = 1'b0;
      end else begin
        m_idle++;
      end
    end
    st_q.push_back('{t, !m_busy, m_owner});
  endtask

  task automatic step();
    model_edge();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    req  = '0;
    vld  = '0;
    eop  = '0;
    data = '0;
  endtask

  task automatic word(input int ch, input logic [DW-1:0] d, input logic last);
    clr();
    vld[ch] = 1'b1;
    eop[ch] = last;
    data[ch*DW +: DW] = d;
    step();
  endtask

  task automatic request(input logic [N-1:0] r);
    clr();
    req = r;
    step();
  endtask

  // Asynchronous reset away from any clock edge; the monitor probes outputs.
  task automatic do_reset();
    clr();
    rst_n = 1'b0;
    #1 rst_probe = 1'b1;
    #1 rst_probe = 1'b0;
    m_busy  = 1'b0;
    m_owner = 0;
    m_ptr   = 0;
    m_idle  = 0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d actual %0h required %0h", name, cyc, act, exp);
    end
  endtask

  // Monitor: all comparisons happen here, mid-cycle or on a reset probe.
  always begin
    @(negedge clk or posedge rst_probe or posedge done);
    if (done) begin
      chk("hs_leftover", 64'(hs_q.size()), 64'd0);
      chk("wr_leftover", 64'(wr_q.size()), 64'd0);
      chk("abort_leftover", 64'(ab_q.size()), 64'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end else if (rst_probe) begin
      chk("rst_resp", 64'(resp), 64'd0);
      chk("rst_nresp", 64'(nresp), 64'd0);
      chk("rst_wr_data", 64'(wr_data), 64'd0);
      chk("rst_wr_vld", 64'(wr_vld), 64'd0);
      chk("rst_wr_eop", 64'(wr_eop), 64'd0);
      chk("rst_grant_id", 64'(grant_id), 64'd0);
      chk("rst_abort", 64'(abort), 64'd0);
      chk("rst_ready", 64'(ready), 64'd1);
      hs_q.delete();
      wr_q.delete();
      ab_q.delete();
      st_q.delete();
    end else if (rst_n) begin
      while (hs_q.size() > 0 && hs_q[0].t < cyc) begin
        chk("hs_stale", 64'(cyc), 64'(hs_q[0].t));
        void'(hs_q.pop_front());
      end
      if (hs_q.size() > 0 && hs_q[0].t == cyc) begin
        hs_t e;
        e = hs_q.pop_front();
        chk("resp", 64'(resp), 64'(e.resp));
        chk("nresp", 64'(nresp), 64'(e.nresp));
      end else begin
        chk("resp_quiet", 64'({resp, nresp}), 64'd0);
      end

      while (wr_q.size() > 0 && wr_q[0].t < cyc) begin
        chk("wr_stale", 64'(cyc), 64'(wr_q[0].t));
        void'(wr_q.pop_front());
      end
      if (wr_q.size() > 0 && wr_q[0].t == cyc) begin
        wr_t e;
        e = wr_q.pop_front();
        chk("wr_vld", 64'(wr_vld), 64'd1);
        chk("wr_data", 64'(wr_data), 64'(e.data));
        chk("wr_eop", 64'(wr_eop), 64'(e.eop));
      end else begin
        chk("wr_quiet", 64'({wr_vld, wr_eop, wr_data}), 64'd0);
      end

      while (ab_q.size() > 0 && ab_q[0] < cyc) begin
        chk("abort_stale", 64'(cyc), 64'(ab_q[0]));
        void'(ab_q.pop_front());
      end
      if (ab_q.size() > 0 && ab_q[0] == cyc) begin
        void'(ab_q.pop_front());
        chk("abort", 64'(abort), 64'd1);
      end else begin
        chk("abort_quiet", 64'(abort), 64'd0);
      end

      while (st_q.size() > 0 && st_q[0].t < cyc) void'(st_q.pop_front());
      if (st_q.size() > 0 && st_q[0].t == cyc) begin
        st_t e;
        e = st_q.pop_front();
        chk("ready", 64'(ready), 64'(e.ready));
        chk("grant_id", 64'(grant_id), 64'(e.gid));
      end
    end
  end

  initial begin
    clr();
    rst_n = 1'b0;
    #2 rst_probe = 1'b1;
    #1 rst_probe = 1'b0;
    m_busy = 1'b0; m_owner = 0; m_ptr = 0; m_idle = 0;
    @(posedge clk);
    @(posedge clk);
    #1 rst_n = 1'b1;

    // Single request right after reset, then close the packet.
    request(16'h0001);
    clr(); step();
    word(0, 32'h0000_0055, 1'b1);
    clr(); step();

    // Round-robin from pointer 0, then the same request picks the next one.
    do_reset();
    request(16'h8006);
    word(1, 32'h0000_0111, 1'b1);
    request(16'h8006);
    word(2, 32'h0000_0222, 1'b1);
    clr(); step();

    // Four-word packet on channel 3.
    request(16'h0008);
    word(3, 32'h0000_00A0, 1'b0);
    word(3, 32'h0000_00A1, 1'b0);
    word(3, 32'h0000_00A2, 1'b0);
    word(3, 32'h0000_00A3, 1'b1);
    clr(); step();

    // Foreign requests and channel-5 data while channel 3 owns the port.
    request(16'h0008);
    word(3, 32'h0000_00B0, 1'b0);
    clr();
    req = 16'h0030;
    vld[5] = 1'b1;
    eop[5] = 1'b1;
    data[5*DW +: DW] = 32'hDEAD_BEEF;
    step();
    word(3, 32'h0000_00B1, 1'b1);
    clr(); step();

    // Silent owner on channel 7 runs into the timeout.
    request(16'h0080);
    clr();
    for (int i = 0; i < 262; i++) step();

    // Reset in the middle of a packet, then restart from pointer 0.
    request(16'h0100);
    word(8, 32'h0000_0811, 1'b0);
    do_reset();
    request(16'h8000);
    word(15, 32'h0000_0F00, 1'b1);
    clr(); step();

    // Randomised traffic.
    for (int i = 0; i < 3000; i++) begin
      clr();
      if ($urandom_range(0, 5) == 0) req = N'($urandom);
      vld = N'($urandom);
      eop = N'($urandom & $urandom & $urandom);
      for (int k = 0; k < N; k++) data[k*DW +: DW] = $urandom;
      step();
    end
    clr();
    for (int i = 0; i < 3; i++) step();

    done = 1'b1;
  end

endmodule
